// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage load or store as two 16-bit accesses to an
// asynchronous SRAM, holding ready low until the word is complete.
`timescale 1ns/1ps

module sram_controller #(
  parameter logic [31:0] ADDR_BASE     = 32'd1024,
  parameter int          SRAM_AW       = 18,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_dq_oe,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          read_data_q, read_data_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic                 sram_we_n_q, sram_we_n_d;
  logic                 sram_dq_oe_q, sram_dq_oe_d;
  logic [15:0]          sram_dq_out_q, sram_dq_out_d;

  logic [31:0]          offset_s;
  logic                 req_s;
  logic                 last_s;
  logic                 unused_offset_s;

  // Only the word index survives; byte-lane bits and bits above the SRAM are dropped.
  assign offset_s        = address - ADDR_BASE;
  assign unused_offset_s = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};
  assign req_s           = rd_en | wr_en;
  assign last_s          = (cnt_q == CNT_LAST);

  // Next-state, phase counter, request latch and read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    data_d      = data_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = PH0;
          cnt_d   = {CW{1'b0}};
          op_wr_d = wr_en;
          word_d  = offset_s[SRAM_AW:2];
          data_d  = write_data;
        end else begin
          state_d = IDLE;
        end
      end
      PH0: begin
        if (last_s) begin
          state_d = PH1;
          cnt_d   = {CW{1'b0}};
          if (!op_wr_q) begin
            read_data_d[15:0] = sram_dq_in;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH1: begin
        if (last_s) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
          if (!op_wr_q) begin
            read_data_d[31:16] = sram_dq_in;
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // SRAM pins are decoded from the upcoming state so the flops present them in that state.
  always_comb begin
    sram_addr_d   = {SRAM_AW{1'b0}};
    sram_we_n_d   = 1'b1;
    sram_dq_oe_d  = 1'b0;
    sram_dq_out_d = 16'd0;
    case (state_d)
      PH0: begin
        sram_addr_d   = {word_d, 1'b0};
        sram_we_n_d   = ~op_wr_d;
        sram_dq_oe_d  = op_wr_d;
        sram_dq_out_d = op_wr_d ? data_d[15:0] : 16'd0;
      end
      PH1: begin
        sram_addr_d   = {word_d, 1'b1};
        sram_we_n_d   = ~op_wr_d;
        sram_dq_oe_d  = op_wr_d;
        sram_dq_out_d = op_wr_d ? data_d[31:16] : 16'd0;
      end
      default: begin
        sram_addr_d   = {SRAM_AW{1'b0}};
        sram_we_n_d   = 1'b1;
        sram_dq_oe_d  = 1'b0;
        sram_dq_out_d = 16'd0;
      end
    endcase
  end

  // Freeze the pipeline from the request cycle until the DONE cycle.
  always_comb begin
    case (state_q)
      IDLE:    ready = ~req_s;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= {CW{1'b0}};
      op_wr_q       <= 1'b0;
      word_q        <= {(SRAM_AW-1){1'b0}};
      data_q        <= 32'd0;
      read_data_q   <= 32'd0;
      sram_addr_q   <= {SRAM_AW{1'b0}};
      sram_we_n_q   <= 1'b1;
      sram_dq_oe_q  <= 1'b0;
      sram_dq_out_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      word_q        <= word_d;
      data_q        <= data_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_dq_out_q <= sram_dq_out_d;
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_dq_out = sram_dq_out_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 2 and 1), each with an
// SRAM array and a transaction-level reference model checked every cycle.
`timescale 1ns/1ps

module tb_sram_controller;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    rd_v = 2'b00;
  logic [1:0]    wr_v = 2'b00;
  logic [31:0]   addr_v [2];
  logic [31:0]   wd_v [2];
  logic [31:0]   rdata_v [2];
  logic [1:0]    ready_v;
  logic [AW-1:0] saddr_v [2];
  logic [1:0]    we_n_v;
  logic [1:0]    oe_v;
  logic [15:0]   dqo_v [2];
  logic [15:0]   dqi0, dqi1;

  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem1 [0:(1<<AW)-1];

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  logic [31:0] seq_addr [20];
  logic [31:0] seq_we [20];
  logic [31:0] seq_oe [20];
  logic [31:0] seq_dq [20];
  logic [31:0] done_rd;
  int          lc;

  sram_controller #(.ADDR_BASE(32'd1024), .SRAM_AW(AW), .ACCESS_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .address(addr_v[0]),
    .write_data(wd_v[0]), .read_data(rdata_v[0]), .ready(ready_v[0]),
    .sram_addr(saddr_v[0]), .sram_we_n(we_n_v[0]), .sram_dq_oe(oe_v[0]),
    .sram_dq_out(dqo_v[0]), .sram_dq_in(dqi0)
  );

  sram_controller #(.ADDR_BASE(32'd1024), .SRAM_AW(AW), .ACCESS_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .address(addr_v[1]),
    .write_data(wd_v[1]), .read_data(rdata_v[1]), .ready(ready_v[1]),
    .sram_addr(saddr_v[1]), .sram_we_n(we_n_v[1]), .sram_dq_oe(oe_v[1]),
    .sram_dq_out(dqo_v[1]), .sram_dq_in(dqi1)
  );

  // Asynchronous SRAMs: combinational read, write latched while we_n is low.
  assign dqi0 = mem0[saddr_v[0]];
  assign dqi1 = mem1[saddr_v[1]];
  always @(posedge clk) begin
    if (we_n_v[0] == 1'b0) mem0[saddr_v[0]] <= dqo_v[0];
    if (we_n_v[1] == 1'b0) mem1[saddr_v[1]] <= dqo_v[1];
  end

  function automatic logic [31:0] hw(input logic [31:0] off, input int ph);
    logic [31:0] t;
    t = ((off >> 2) << 1) + 32'(ph);
    return t & 32'h0003_FFFF;
  endfunction

  // Reference: a transaction is cycle k=1..2*AC+1 after acceptance; halves read at k=AC and k=2*AC.
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int AC = (g == 0) ? 2 : 1;
    bit          busy = 1'b0;
    int          k = 0;
    bit          m_wr = 1'b0;
    logic [31:0] m_off = 32'd0;
    logic [31:0] m_dat = 32'd0;
    logic [31:0] m_rd = 32'd0;

    always @(posedge clk) begin
      if (rst) begin
        busy <= 1'b0;
        m_rd <= 32'd0;
      end else if (busy) begin
        if (!m_wr && k == AC)
          m_rd[15:0] <= (g == 0) ? mem0[hw(m_off, 0)] : mem1[hw(m_off, 0)];
        if (!m_wr && k == 2*AC)
          m_rd[31:16] <= (g == 0) ? mem0[hw(m_off, 1)] : mem1[hw(m_off, 1)];
        if (k == 2*AC + 1) busy <= 1'b0;
        else k <= k + 1;
      end else if (rd_v[g] | wr_v[g]) begin
        busy  <= 1'b1;
        k     <= 1;
        m_wr  <= wr_v[g];
        m_off <= addr_v[g] - 32'd1024;
        m_dat <= wd_v[g];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cmp_inst(input int i, input int ac, input bit busy, input int k, input bit w,
                          input logic [31:0] off, input logic [31:0] dat, input logic [31:0] rdx);
    logic [31:0] e_rdy, e_addr, e_we, e_oe, e_dq;
    int ph;
    e_rdy = 32'd1; e_addr = 32'd0; e_we = 32'd1; e_oe = 32'd0; e_dq = 32'd0;
    if (!busy) begin
      e_rdy = (rd_v[i] | wr_v[i]) ? 32'd0 : 32'd1;
    end else if (k <= 2*ac) begin
      ph     = (k > ac) ? 1 : 0;
      e_rdy  = 32'd0;
      e_addr = hw(off, ph);
      e_we   = w ? 32'd0 : 32'd1;
      e_oe   = w ? 32'd1 : 32'd0;
      e_dq   = w ? ((ph == 1) ? {16'd0, dat[31:16]} : {16'd0, dat[15:0]}) : 32'd0;
    end
    check($sformatf("u%0d.ready", i), {31'd0, ready_v[i]}, e_rdy);
    check($sformatf("u%0d.sram_addr", i), {14'd0, saddr_v[i]}, e_addr);
    check($sformatf("u%0d.sram_we_n", i), {31'd0, we_n_v[i]}, e_we);
    check($sformatf("u%0d.sram_dq_oe", i), {31'd0, oe_v[i]}, e_oe);
    check($sformatf("u%0d.sram_dq_out", i), {16'd0, dqo_v[i]}, e_dq);
    check($sformatf("u%0d.read_data", i), rdata_v[i], rdx);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, 2, g_model[0].busy, g_model[0].k, g_model[0].m_wr,
               g_model[0].m_off, g_model[0].m_dat, g_model[0].m_rd);
      cmp_inst(1, 1, g_model[1].busy, g_model[1].k, g_model[1].m_wr,
               g_model[1].m_off, g_model[1].m_dat, g_model[1].m_rd);
    end
  end

  // Issue one request and record the pins of every ready-low cycle (bounded).
  task automatic run_txn(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, input logic [31:0] a_chg,
                         output int lowcnt);
    rd_v[i] = rd; wr_v[i] = wr; addr_v[i] = a; wd_v[i] = d;
    lowcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready_v[i]) break;
      seq_addr[c] = {14'd0, saddr_v[i]};
      seq_we[c]   = {31'd0, we_n_v[i]};
      seq_oe[c]   = {31'd0, oe_v[i]};
      seq_dq[c]   = {16'd0, dqo_v[i]};
      lowcnt++;
      @(posedge clk); #2;
      if (!hold) begin
        rd_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = a_chg;
      end
    end
    done_rd = rdata_v[i];
    @(posedge clk); #2;
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem0[a] <= 16'd0;
      mem1[a] <= 16'd0;
    end
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = 32'd0; wd_v[i] = 32'd0;
    end
    rst = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset ready", {31'd0, ready_v[0]}, 32'd1);
    check("reset read_data", rdata_v[0], 32'd0);
    check("reset we_n/oe", {30'd0, we_n_v[0], oe_v[0]}, 32'd2);
    @(posedge clk); #2 rst = 1'b0;

    run_txn(0, 1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 32'd0, lc);
    check("write low cycles", 32'(lc), 32'd5);
    check("write ph0 addr", seq_addr[1], 32'd0);
    check("write ph0 dq", seq_dq[2], 32'h0000_BEEF);
    check("write ph0 we_n", seq_we[1], 32'd0);
    check("write ph1 addr", seq_addr[4], 32'd1);
    check("write ph1 dq", seq_dq[3], 32'h0000_DEAD);
    check("sram[0]", {16'd0, mem0[0]}, 32'h0000_BEEF);
    check("sram[1]", {16'd0, mem0[1]}, 32'h0000_DEAD);

    run_txn(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd0, lc);
    check("read low cycles", 32'(lc), 32'd5);
    check("read data", done_rd, 32'hDEAD_BEEF);
    check("read we_n", seq_we[1] & seq_we[2] & seq_we[3] & seq_we[4], 32'd1);
    check("read oe", seq_oe[1] | seq_oe[2] | seq_oe[3] | seq_oe[4], 32'd0);

    run_txn(0, 1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 1'b0, 32'd0, lc);
    check("addr 1032 lo", seq_addr[1], 32'd4);
    check("addr 1032 hi", seq_addr[3], 32'd5);
    run_txn(0, 1'b1, 1'b0, 32'd1035, 32'd0, 1'b0, 32'd0, lc);
    check("addr 1035 lo", seq_addr[2], 32'd4);
    check("addr 1035 hi", seq_addr[4], 32'd5);
    check("read 1035 data", done_rd, 32'hCAFE_F00D);

    run_txn(0, 1'b0, 1'b1, 32'd1020, 32'h0123_4567, 1'b0, 32'd0, lc);
    check("wrap lo addr", seq_addr[1], 32'h0003_FFFE);
    check("wrap hi addr", seq_addr[3], 32'h0003_FFFF);

    run_txn(0, 1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b0, 32'd2048, lc);
    check("priority we_n", seq_we[1], 32'd0);
    check("latched addr", seq_addr[3], 32'd1);
    check("priority sram[0]", {16'd0, mem0[0]}, 32'h0000_5678);
    check("write keeps read_data", done_rd, 32'hCAFE_F00D);

    // Abort a write during its first high-halfword cycle.
    wr_v[0] = 1'b1; addr_v[0] = 32'd1024; wd_v[0] = 32'h55AA_33CC;
    @(posedge clk); #2 wr_v[0] = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("abort we_n/oe", {30'd0, we_n_v[0], oe_v[0]}, 32'd2);
    check("abort read_data", rdata_v[0], 32'd0);
    check("abort sram[0]", {16'd0, mem0[0]}, 32'h0000_33CC);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("after abort ready", {31'd0, ready_v[0]}, 32'd1);
    @(posedge clk); #2;

    run_txn(0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 32'd1024, lc);
    check("b2b first low cycles", 32'(lc), 32'd5);
    check("b2b first data", done_rd, 32'h55AA_33CC);
    @(negedge clk);
    check("b2b restart ready", {31'd0, ready_v[0]}, 32'd0);
    @(posedge clk); #2 rd_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    @(negedge clk);
    check("b2b settle ready", {31'd0, ready_v[0]}, 32'd1);
    @(posedge clk); #2;

    run_txn(1, 1'b0, 1'b1, 32'd1024, 32'hA5A5_5A5A, 1'b0, 32'd0, lc);
    check("ac1 write low cycles", 32'(lc), 32'd3);
    check("ac1 lo dq", seq_dq[1], 32'h0000_5A5A);
    check("ac1 hi addr", seq_addr[2], 32'd1);
    check("ac1 hi dq", seq_dq[2], 32'h0000_A5A5);
    run_txn(1, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd0, lc);
    check("ac1 read low cycles", 32'(lc), 32'd3);
    check("ac1 read data", done_rd, 32'hA5A5_5A5A);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
